// File: rtl/call_return_ctrl_if.sv
// Bundle between the call/return controller and its surroundings: request
// inputs from the fetch stage, the return-address stack port, and status.
//
// Handshake semantics: call/ret are level requests, sampled only on a rising
// edge where the controller is in IDLE (busy=0); no ready signal exists and
// a request seen while busy is dropped, not queued. stk_push, stk_pop and
// redirect_valid are single-cycle strobes qualifying stk_wdata and
// redirect_pc respectively; stk_rdata is valid the cycle after stk_pop.
interface call_return_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2
);
  localparam int LW = $clog2(DEPTH + 1);

  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic              stk_push;
  logic              stk_pop;
  logic [ADDR_W-1:0] stk_wdata;
  logic [ADDR_W-1:0] stk_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              busy;
  logic [LW-1:0]     level;
  logic              fault;
  logic              fault_clr;

  // Environment side: fetch stage plus the stack itself.
  modport master (
    output call, ret, pc, target, stk_rdata, fault_clr,
    input  stk_push, stk_pop, stk_wdata, redirect_valid, redirect_pc,
           busy, level, fault
  );

  // Controller side.
  modport slave (
    input  call, ret, pc, target, stk_rdata, fault_clr,
    output stk_push, stk_pop, stk_wdata, redirect_valid, redirect_pc,
           busy, level, fault
  );
endinterface

// File: rtl/call_return_ctrl.sv
// Call/return controller driving an external return-address stack.
// A call pushes pc+1 and redirects to target one cycle later; a return pops
// the stack, waits for the registered read data and redirects to it three
// cycles later. All outputs are registered.
// Optional feature macro: RAS_TRAP_EN -- overflow/underflow enters a FAULT
// state (cleared by fault_clr) instead of redirecting without stack access.
module call_return_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  call_return_ctrl_if.slave bus,
  output logic [2:0]        state_dbg
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

`ifdef RAS_TRAP_EN
  typedef enum logic [2:0] {IDLE, PUSH, POP, WAIT, RET_OUT, FAULT} state_t;
`else
  typedef enum logic [2:0] {IDLE, PUSH, POP, WAIT, RET_OUT} state_t;
`endif

  state_t            state_q, state_d;
  logic [LW-1:0]     level_q;
  logic              push_q, push_d;
  logic              pop_q, pop_d;
  logic [ADDR_W-1:0] wdata_q, wdata_d;
  logic              rv_q, rv_d;
  logic [ADDR_W-1:0] rpc_q, rpc_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  // Set for a return issued on an empty stack: the POP/WAIT slots run
  // without touching the stack and the redirect carries address 0.
  logic              phantom_q, phantom_d;

  // Next state and next registered outputs; strobes default low each cycle.
  always_comb begin
    state_d   = state_q;
    push_d    = 1'b0;
    pop_d     = 1'b0;
    wdata_d   = '0;
    rv_d      = 1'b0;
    rpc_d     = '0;
    fault_d   = 1'b0;
    phantom_d = phantom_q;
    case (state_q)
      IDLE: begin
        if (bus.call) begin
          if (level_q < FULL) begin
            state_d = PUSH;
            push_d  = 1'b1;
            wdata_d = bus.pc + ADDR_W'(1);
            rv_d    = 1'b1;
            rpc_d   = bus.target;
          end else begin
`ifdef RAS_TRAP_EN
            state_d = FAULT;
            fault_d = 1'b1;
`else
            // Overflow: redirect anyway, the return address is lost.
            state_d = RET_OUT;
            rv_d    = 1'b1;
            rpc_d   = bus.target;
`endif
          end
        end else if (bus.ret) begin
          if (level_q != '0) begin
            state_d   = POP;
            pop_d     = 1'b1;
            phantom_d = 1'b0;
          end else begin
`ifdef RAS_TRAP_EN
            state_d = FAULT;
            fault_d = 1'b1;
`else
            state_d   = POP;
            phantom_d = 1'b1;
`endif
          end
        end
      end
      PUSH:    state_d = IDLE;
      POP:     state_d = WAIT;
      WAIT: begin
        state_d = RET_OUT;
        rv_d    = 1'b1;
        rpc_d   = phantom_q ? '0 : bus.stk_rdata;
      end
      RET_OUT: state_d = IDLE;
`ifdef RAS_TRAP_EN
      FAULT: begin
        if (bus.fault_clr) state_d = IDLE;
        else               fault_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, occupancy and output registers; level moves when leaving PUSH/POP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      level_q   <= '0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      wdata_q   <= '0;
      rv_q      <= 1'b0;
      rpc_q     <= '0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      phantom_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      push_q    <= push_d;
      pop_q     <= pop_d;
      wdata_q   <= wdata_d;
      rv_q      <= rv_d;
      rpc_q     <= rpc_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
      phantom_q <= phantom_d;
      if (state_q == PUSH)
        level_q <= level_q + LW'(1);
      else if (state_q == POP && !phantom_q)
        level_q <= level_q - LW'(1);
    end
  end

  assign bus.stk_push       = push_q;
  assign bus.stk_pop        = pop_q;
  assign bus.stk_wdata      = wdata_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.busy           = busy_q;
  assign bus.level          = level_q;
  assign state_dbg          = state_q;

`ifdef RAS_TRAP_EN
  assign bus.fault = fault_q;
`else
  // No trap logic: fault is constant and fault_clr has no effect.
  logic unused_fault;
  assign unused_fault = fault_q | bus.fault_clr;
  assign bus.fault    = 1'b0;
`endif
endmodule
